// File: rtl/shared_alu_arbiter.sv
// shared_alu_arbiter: round-robin sharing of one ALU among req/ack clients.
// Define SHARED_ALU_MUL_EN to build the multiplier; otherwise opcode 10 yields 0.
module shared_alu_arbiter #(
    parameter int data_width  = 32,
    parameter int num_clients = 4,
    parameter int exec_cycles = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [num_clients-1:0]              req,
    input  logic [2*num_clients-1:0]            op,
    input  logic [data_width*num_clients-1:0]   din_a,
    input  logic [data_width*num_clients-1:0]   din_b,
    output logic [num_clients-1:0]              ack,
    output logic [data_width-1:0]               dout,
    output logic [$clog2(num_clients)-1:0]      grant_id,
    output logic                                busy
);
    localparam int iw = $clog2(num_clients);
    localparam int cw = exec_cycles > 1 ? $clog2(exec_cycles) : 1;

    typedef enum logic [2:0] {IDLE, GRANT, EXEC, RESP, GAP} state_t;

    state_t                state, state_nx;
    logic [1:0]            rst_sync;
    logic [iw-1:0]         ptr, sel;
    logic                  found;
    logic [cw-1:0]         cnt;
    logic [1:0]            op_q;
    logic [data_width-1:0] a_q, b_q, prod, result;

    // Scan downward so the closest requester at or after ptr wins.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int k = num_clients - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % num_clients]) begin
                found = 1'b1;
                sel   = iw'((int'(ptr) + k) % num_clients);
            end
        end
    end

`ifdef SHARED_ALU_MUL_EN
    assign prod = a_q * b_q;
`else
    assign prod = '0;
`endif

    always_comb begin
        result = op_q == 2'b00 ? a_q + b_q :
                 op_q == 2'b01 ? a_q - b_q :
                 op_q == 2'b10 ? prod : a_q;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (rst_sync[1] && found) ? GRANT : IDLE;
            GRANT:   state_nx = EXEC;
            EXEC:    state_nx = (cnt == '0) ? RESP : EXEC;
            RESP:    state_nx = GAP;
            GAP:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = state != IDLE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            rst_sync <= '0;
            ptr      <= '0;
            grant_id <= '0;
            cnt      <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            ack      <= '0;
            dout     <= '0;
        end else begin
            state    <= state_nx;
            rst_sync <= {rst_sync[0], 1'b1};
            ack      <= (state == EXEC && cnt == '0) ? {{(num_clients-1){1'b0}}, 1'b1} << grant_id : '0;
            if (state == IDLE && state_nx == GRANT)
                grant_id <= sel;
            if (state == GRANT) begin
                op_q <= op[2*int'(grant_id) +: 2];
                a_q  <= din_a[data_width*int'(grant_id) +: data_width];
                b_q  <= din_b[data_width*int'(grant_id) +: data_width];
                cnt  <= cw'(exec_cycles - 1);
            end
            if (state == EXEC && cnt != '0)
                cnt <= cnt - 1'b1;
            if (state == EXEC && cnt == '0)
                dout <= result;
            if (state == RESP)
                ptr <= (grant_id == iw'(num_clients - 1)) ? '0 : grant_id + 1'b1;
        end
    end
endmodule

// File: tb/tb_shared_alu_arbiter.sv
// tb_shared_alu_arbiter: directed and randomized checks against a reference model.
module tb_shared_alu_arbiter;
    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [7:0]   op;
    logic [127:0] din_a, din_b;
    logic [3:0]   ack;
    logic [31:0]  dout;
    logic [1:0]   grant_id;
    logic         busy;

    int errors = 0;
    int checks = 0;
    int m_ptr  = 0;
    logic [1:0]  ro[4];
    logic [31:0] ra[4], rb[4];

`ifdef SHARED_ALU_MUL_EN
    localparam logic [31:0] mul_exp = 32'd42;
`else
    localparam logic [31:0] mul_exp = 32'd0;
`endif

    always #5 clk = ~clk;

    shared_alu_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .din_a(din_a), .din_b(din_b),
        .ack(ack), .dout(dout), .grant_id(grant_id), .busy(busy)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] m;
`ifdef SHARED_ALU_MUL_EN
        m = a * b;
`else
        m = '0;
`endif
        return o == 2'd0 ? a + b : o == 2'd1 ? a - b : o == 2'd2 ? m : a;
    endfunction

    function automatic int pick(input logic [3:0] mask, input int p);
        for (int k = 0; k < 4; k++)
            if (mask[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    task automatic set_client(input int c, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        ro[c] = o;
        ra[c] = a;
        rb[c] = b;
        op[2*c +: 2]     = o;
        din_a[32*c +: 32] = a;
        din_b[32*c +: 32] = b;
    endtask

    task automatic new_ops(input int c);
        logic [31:0] a, b;
        a = $urandom_range(1) ? $urandom : $urandom_range(20);
        b = $urandom_range(1) ? $urandom : $urandom_range(20);
        set_client(c, 2'($urandom_range(3)), a, b);
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        for (int i = 1; i <= 40 && n == 0; i++) begin
            @(negedge clk);
            if (ack != 4'b0) n = i;
        end
    endtask

    task automatic single(input string tag, input int c, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int n;
        set_client(c, o, a, b);
        req[c] = 1'b1;
        wait_ack(n);
        check({tag, " latency"}, 32'(n), 32'd4);
        check({tag, " ack"}, 32'(ack), 32'(4'b1 << c));
        check({tag, " dout"}, dout, exp);
        check({tag, " grant_id"}, 32'(grant_id), 32'(c));
        check({tag, " busy"}, 32'(busy), 32'd1);
        req[c] = 1'b0;
        m_ptr = (c + 1) % 4;
        repeat (2) @(negedge clk);
        check({tag, " idle"}, 32'({busy, ack}), 32'd0);
    endtask

    initial begin
        int n, c, extra;
        bit cont;
        req = '0; op = '0; din_a = '0; din_b = '0;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("rst ack", 32'(ack), 0);
        check("rst dout", dout, 0);
        check("rst grant_id", 32'(grant_id), 0);
        check("rst busy", 32'(busy), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        single("add", 2, 2'd0, 32'd5, 32'd7, 32'd12);
        single("sub", 0, 2'd1, 32'd3, 32'd5, 32'hFFFF_FFFE);
        single("wrap", 1, 2'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
        single("mul_trunc", 3, 2'd2, 32'h1_0000, 32'h1_0000, 32'd0);
        single("mul", 2, 2'd2, 32'd6, 32'd7, mul_exp);
        single("pass", 1, 2'd3, 32'h1234, 32'd99, 32'h1234);

        // operand hold and req drop during EXEC
        set_client(0, 2'd0, 32'd1, 32'd2);
        req[0] = 1'b1;
        repeat (2) @(negedge clk);
        din_a[31:0] = 32'd9;
        req[0] = 1'b0;
        wait_ack(n);
        check("hold latency", 32'(n), 32'd2);
        check("hold ack", 32'(ack), 32'd1);
        check("hold dout", dout, 32'd3);
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack != 4'b0) extra++;
        end
        check("hold single ack", 32'(extra), 0);
        m_ptr = 1;

        // round robin with all clients busy, then randomized traffic
        for (int i = 0; i < 4; i++) new_ops(i);
        req = 4'hF;
        cont = 1'b0;
        for (int it = 0; it < 40; it++) begin
            c = pick(req, m_ptr);
            wait_ack(n);
            check($sformatf("rr%0d ack", it), 32'(ack), 32'(4'b1 << c));
            check($sformatf("rr%0d grant_id", it), 32'(grant_id), 32'(c));
            check($sformatf("rr%0d dout", it), dout, model(ro[c], ra[c], rb[c]));
            if (cont) check($sformatf("rr%0d spacing", it), 32'(n), 32'd6);
            m_ptr = (c + 1) % 4;
            if (it < 8 || $urandom_range(3) != 0) new_ops(c);
            else req[c] = 1'b0;
            cont = req != 4'b0;
            if (!cont) begin
                repeat (3) @(negedge clk);
                c = $urandom_range(3);
                new_ops(c);
                req[c] = 1'b1;
            end
        end

        // reset mid-EXEC with client 1 granted
        req = '0;
        repeat (8) @(negedge clk);
        set_client(1, 2'd0, 32'd10, 32'd20);
        req[1] = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort ack", 32'(ack), 0);
        check("abort dout", dout, 0);
        check("abort grant_id", 32'(grant_id), 0);
        check("abort busy", 32'(busy), 0);
        for (int i = 0; i < 4; i++) new_ops(i);
        req = 4'hF;
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ack != 4'b0) extra++;
        end
        check("abort no ack", 32'(extra), 0);
        rst = 1'b1;
        wait_ack(n);
        check("post rst ack", 32'(ack), 32'd1);
        check("post rst grant_id", 32'(grant_id), 0);
        check("post rst dout", dout, model(ro[0], ra[0], rb[0]));
        check("post rst sync delay", 32'(n >= 5), 32'd1);
        req = '0;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/shared_alu_arbiter.md
# shared_alu_arbiter

Round-robin arbiter that shares one arithmetic unit among `num_clients` dataflow requesters using the codebase's req/ack handshake. Each client raises `req` with an opcode and two operands. The arbiter grants one client at a time, holds the operands while the unit executes for `exec_cycles`, then returns the result with a one-cycle `ack`. It sits between several `async_operator`-style consumers and a single area-expensive ALU, so multiple graph nodes can map onto one physical operator.

## Interface
- `data_width`, 32, operand/result width
- `num_clients`, 4, number of requesters (2..8)
- `exec_cycles`, 2, cycles spent in EXEC (≥1)
- `clk` input 1: sole clock, rising edge
- `rst` input 1: asynchronous, active-low reset
- `req` input `num_clients`: per-client request level
- `op` input `2*num_clients`: client i opcode at `[2i+1:2i]`; 00 add, 01 sub (a−b), 10 mul, 11 pass a
- `din_a` input `data_width*num_clients`: client i operand a at slice i
- `din_b` input `data_width*num_clients`: client i operand b at slice i
- `ack` output `num_clients`: one-hot, one-cycle result-valid pulse
- `dout` output `data_width`: result, valid in the `ack` cycle and held until the next result
- `grant_id` output `$clog2(num_clients)`: index of the current or last granted client
- `busy` output 1: high in GRANT, EXEC, RESP and GAP

## Operation
- FSM states: IDLE, GRANT, EXEC, RESP, GAP.
- **IDLE**
  - If any `req` is high, select the first requesting client at or after `ptr` (circular search) and go to GRANT.
  - Update `grant_id` to the selected client.
- **GRANT**
  - Capture `op`, `din_a`, `din_b` slices of `grant_id` into internal registers.
  - Load `cnt = exec_cycles-1` and go to EXEC.
  - Operands are sampled only here; later input changes have no effect.
- **EXEC**
  - Compute from the captured operands; the result is registered on exit.
  - If `cnt == 0`, go to RESP; otherwise decrement `cnt`.
- **RESP**
  - `ack[grant_id]=1` and `dout=result` for exactly one cycle.
  - Set `ptr = grant_id+1`, wrapping to 0 at `num_clients`; go to GAP.
- **GAP**
  - One dead cycle that absorbs the client's req drop. Clients clear `req` on the `ack` edge, so `req` may still read high in this cycle.
  - `req` is ignored; return to IDLE.
- **Arithmetic**
  - All results are truncated modulo 2^`data_width`; sub wraps.
  - mul keeps the low `data_width` bits.
- **Boundary rules**
  - A `req` dropped after GRANT does not abort the operation; the ack still fires.
  - `req` high for a client that is not granted has no effect until it is selected.
  - Simultaneous requests: strict round robin from `ptr`, so no client waits more than `num_clients-1` services.
  - Reset asserted mid-operation aborts immediately; no ack is issued for the aborted operation.
- **Reset values**
  - Outputs: `ack=0`, `dout=0`, `grant_id=0`, `busy=0`.
  - Internal: FSM in IDLE, `ptr=0`, `cnt=0`.

## Timing
- Latency from `req` sampled high in IDLE to `ack`: 2+`exec_cycles` cycles (GRANT, EXEC×`exec_cycles`, RESP).
- Service period per operation: 4+`exec_cycles` cycles including IDLE and GAP. Back-to-back throughput with default parameters is 1 result per 6 cycles.
- `busy` rises the cycle after IDLE grants and falls on entry to IDLE.
- Reset release is synchronized internally: the FSM leaves IDLE no earlier than the second rising edge after `rst` goes high.

## Configuration
- **`SHARED_ALU_MUL_EN` defined:** opcode 10 performs a `data_width`×`data_width` multiply with the low bits kept.
- **`SHARED_ALU_MUL_EN` undefined:**
  - No multiplier is synthesized.
  - Opcode 10 yields `dout=0`, with normal handshake timing and the ack still issued.

## Test plan
- **Reset:** assert `rst=0` mid-EXEC with client 1 granted → no `ack` ever pulses; all outputs read 0; after release, the first grant goes to client 0 if requesting.
- **Single client add:** client 2 drives `req`, op=00, a=5, b=7, default parameters → `ack=4'b0100` and `dout=12` exactly 4 cycles after IDLE samples req.
- **Round robin:** all four clients request continuously with distinct operands → ack order 0,1,2,3,0; every ack is 6 cycles apart; `grant_id` matches each ack.
- **Wrap/sub:** op=01, a=3, b=5 → `dout=32'hFFFFFFFE`; op=00, a=32'hFFFFFFFF, b=1 → `dout=0`.
- **Multiply:** op=10, a=32'h10000, b=32'h10000 → `dout=0` (truncated); a=6, b=7 → 42 with `SHARED_ALU_MUL_EN` defined, 0 without it.
- **Operand hold:** change client 0's `din_a` from 1 to 9 during EXEC → `dout` reflects 1; drop `req` during EXEC → `ack` still pulses once.
